// File: rtl/fetch_packet_gen_if.sv
// Fetch-unit bundle: redirect/back-pressure from the core, I-cache request/response,
// and the fetch packet toward decode.
interface fetch_packet_gen_if;
  logic         redirect_i;
  logic [31:0]  redirectPC_i;
  logic         ID_stopFetch_i;

  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_addr_ok;
  logic         inst_data_ok;
  logic [127:0] inst_rdata;
  logic         inst_excOccur;
  logic [4:0]   inst_excCode;
  logic         inst_isRefill;

  logic         IF_valid_o;
  logic [3:0]   IF_instEnable_o;
  logic [127:0] IF_inst_p_o;
  logic [2:0]   IF_instNum_o;
  logic [31:0]  IF_instBasePC_o;
  logic         IF_hasException_o;
  logic [4:0]   IF_ExcCode_o;
  logic         IF_isRefill_o;

  modport master (
    input  redirect_i, redirectPC_i, ID_stopFetch_i,
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata, inst_excOccur, inst_excCode, inst_isRefill,
    output IF_valid_o, IF_instEnable_o, IF_inst_p_o, IF_instNum_o, IF_instBasePC_o,
    output IF_hasException_o, IF_ExcCode_o, IF_isRefill_o
  );

  modport slave (
    output redirect_i, redirectPC_i, ID_stopFetch_i,
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata, inst_excOccur, inst_excCode, inst_isRefill,
    input  IF_valid_o, IF_instEnable_o, IF_inst_p_o, IF_instNum_o, IF_instBasePC_o,
    input  IF_hasException_o, IF_ExcCode_o, IF_isRefill_o
  );
endinterface

// File: rtl/fetch_packet_gen.sv
// Instruction fetch: issues one 16-byte I-cache request at a time and turns each
// response into a lane-aligned fetch packet, handling redirects and misaligned PCs.
module fetch_packet_gen #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [4:0]  ADEL_CODE = 5'h04
) (
  input  logic             clk,
  input  logic             rst,
  fetch_packet_gen_if.master bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned BLK   = LANES * XLEN;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_CANCEL, S_HALT} state_t;

  typedef struct packed {
    logic             valid;
    logic [LANES-1:0] en;
    logic [BLK-1:0]   inst;
    logic [2:0]       num;
    logic [XLEN-1:0]  base;
    logic             exc;
    logic [4:0]       code;
    logic             refill;
  } pkt_t;

  state_t                       state, state_nxt;
  logic [XLEN-1:0]              pc, pc_nxt;
  pkt_t                         pkt, pkt_nxt;
  logic                         req_c;
  logic                         accept;
  logic                         misaligned;
  logic                         emit_data;
  logic                         emit_adel;
  logic [1:0]                   off;
  logic [LANES-1:0][XLEN-1:0]   blk;
  logic [LANES-1:0][XLEN-1:0]   lanes;
  logic [LANES-1:0]             lane_en;
  logic [2:0]                   lane_num;

  assign misaligned = pc[1:0] != 2'b00;
  assign off        = pc[3:2];
  assign blk        = bus.inst_rdata;

  // Request only from REQ with an aligned PC; rst gating keeps outputs quiet in reset.
  assign req_c  = rst && (state == S_REQ) && !misaligned && !bus.ID_stopFetch_i;
  assign accept = req_c && bus.inst_addr_ok;

  assign emit_data = (state == S_WAIT) && bus.inst_data_ok && !bus.redirect_i;
  assign emit_adel = (state == S_REQ) && misaligned && !bus.redirect_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_REQ;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (bus.redirect_i)   state_nxt = accept ? S_CANCEL : S_REQ;
        else if (misaligned)  state_nxt = S_HALT;
        else if (accept)      state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect_i)        state_nxt = bus.inst_data_ok ? S_REQ : S_CANCEL;
        else if (bus.inst_data_ok) state_nxt = bus.inst_excOccur ? S_HALT : S_REQ;
      end
      S_CANCEL: begin
        if (bus.inst_data_ok) state_nxt = S_REQ;
      end
      S_HALT: begin
        if (bus.redirect_i) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Lane i takes block word off+i; lanes past the block end stay disabled and zero.
  always_comb begin
    lanes   = '0;
    lane_en = '0;
    for (int i = 0; i < LANES; i++) begin
      if (3'(i) + {1'b0, off} < 3'(LANES)) begin
        lane_en[2'(i)] = 1'b1;
        lanes[2'(i)]   = blk[2'(i) + off];
      end
    end
  end

  assign lane_num = 3'(LANES) - {1'b0, off};

  always_comb begin
    pkt_nxt       = pkt;
    pkt_nxt.valid = 1'b0;
    pc_nxt        = pc;

    if (bus.redirect_i)
      pc_nxt = bus.redirectPC_i;
    else if (emit_data && !bus.inst_excOccur)
      pc_nxt = {pc[XLEN-1:4] + 28'd1, 4'b0000};

    if (emit_adel) begin
      pkt_nxt.valid  = 1'b1;
      pkt_nxt.en     = 4'b0001;
      pkt_nxt.inst   = '0;
      pkt_nxt.num    = 3'd1;
      pkt_nxt.base   = pc;
      pkt_nxt.exc    = 1'b1;
      pkt_nxt.code   = ADEL_CODE;
      pkt_nxt.refill = 1'b0;
    end else if (emit_data) begin
      pkt_nxt.valid  = 1'b1;
      pkt_nxt.en     = lane_en;
      pkt_nxt.inst   = lanes;
      pkt_nxt.num    = lane_num;
      pkt_nxt.base   = pc;
      pkt_nxt.exc    = bus.inst_excOccur;
      pkt_nxt.code   = bus.inst_excCode;
      pkt_nxt.refill = bus.inst_isRefill;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= RESET_PC;
      pkt <= '0;
    end else begin
      pc  <= pc_nxt;
      pkt <= pkt_nxt;
    end
  end

  assign bus.inst_req          = req_c;
  assign bus.inst_addr         = rst ? {pc[XLEN-1:4], 4'b0000} : '0;
  assign bus.IF_valid_o        = pkt.valid;
  assign bus.IF_instEnable_o   = pkt.en;
  assign bus.IF_inst_p_o       = pkt.inst;
  assign bus.IF_instNum_o      = pkt.num;
  assign bus.IF_instBasePC_o   = pkt.base;
  assign bus.IF_hasException_o = pkt.exc;
  assign bus.IF_ExcCode_o      = pkt.code;
  assign bus.IF_isRefill_o     = pkt.refill;

endmodule

// File: tb/tb_fetch_packet_gen.sv
// Bench for fetch_packet_gen: directed scenarios with literal expectations, then a
// randomized run against a transaction-level fetch model and a simple I-cache responder.
module tb_fetch_packet_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_packet_gen_if bus ();

  fetch_packet_gen #(.RESET_PC(32'hBFC0_0000), .ADEL_CODE(5'h04)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Stimulus knobs and cache responder state
  int           ok_pct, lat_lo, lat_hi, exc_pct;
  bit           fixed_data, force_exc, stop;
  logic [127:0] fixed_rdata;
  bit           c_pend;
  int           c_wait;

  // Model: architectural fetch PC, one outstanding request, drop flag, halted flag
  logic [31:0]  m_pc;
  bit           m_out, m_disc, m_halt;

  bit           e_valid, e_exc, e_ref;
  logic [3:0]   e_en;
  logic [2:0]   e_num;
  logic [127:0] e_lanes;
  logic [31:0]  e_base;
  logic [4:0]   e_code;

  bit           got_req, got_valid, got_exc, got_ref;
  logic [31:0]  got_addr, got_base;
  logic [3:0]   got_en;
  logic [2:0]   got_num;
  logic [127:0] got_lanes;
  logic [4:0]   got_code;
  int           n_req_seen, n_valid_seen;

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endfunction

  // One clock cycle; entered and left just after a falling edge.
  task automatic cycle(input bit redir, input logic [31:0] tgt);
    bit exp_req, acc;
    int cnt, base_w;
    bus.redirect_i     = redir;
    bus.redirectPC_i   = tgt;
    bus.ID_stopFetch_i = stop;
    bus.inst_data_ok   = 1'b0;
    bus.inst_excOccur  = 1'b0;
    bus.inst_excCode   = 5'h00;
    bus.inst_isRefill  = 1'b0;
    bus.inst_rdata     = fixed_data ? fixed_rdata : {$urandom(), $urandom(), $urandom(), $urandom()};
    if (c_pend) begin
      if (c_wait == 0) begin
        bus.inst_data_ok = 1'b1;
        if (force_exc) begin
          bus.inst_excOccur = 1'b1;
          bus.inst_excCode  = 5'h03;
          bus.inst_isRefill = 1'b1;
        end else if ($urandom_range(0, 99) < exc_pct) begin
          bus.inst_excOccur = 1'b1;
          bus.inst_excCode  = 5'($urandom());
          bus.inst_isRefill = 1'($urandom());
        end
      end else begin
        c_wait--;
      end
    end
    bus.inst_addr_ok = ($urandom_range(0, 99) < ok_pct);
    #1;
    exp_req = !m_out && !m_halt && (m_pc[1:0] == 2'b00) && !stop;
    chk("inst_req", bus.inst_req, exp_req);
    if (exp_req) chk("inst_addr", bus.inst_addr, {m_pc[31:4], 4'h0});
    got_req  = bus.inst_req;
    got_addr = bus.inst_addr;
    if (got_req) n_req_seen++;
    acc = exp_req && bus.inst_addr_ok;

    e_valid = 1'b0;
    if (redir) begin
      if (bus.inst_data_ok) begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end else if (acc) begin
        m_out = 1'b1;
      end
      if (m_out) m_disc = 1'b1;
      m_halt = 1'b0;
      m_pc   = tgt;
    end else if (m_out) begin
      if (bus.inst_data_ok) begin
        m_out = 1'b0;
        if (m_disc) begin
          m_disc = 1'b0;
        end else begin
          base_w  = int'(m_pc[3:2]);
          cnt     = 4 - base_w;
          e_valid = 1'b1;
          e_en    = 4'((1 << cnt) - 1);
          e_num   = 3'(cnt);
          e_lanes = '0;
          for (int i = 0; i < cnt; i++) e_lanes[32*i +: 32] = bus.inst_rdata[32*(base_w+i) +: 32];
          e_base  = m_pc;
          e_exc   = bus.inst_excOccur;
          e_code  = bus.inst_excCode;
          e_ref   = bus.inst_isRefill;
          if (bus.inst_excOccur) m_halt = 1'b1;
          else m_pc = (m_pc & ~32'hF) + 32'h10;
        end
      end
    end else if (!m_halt) begin
      if (m_pc[1:0] != 2'b00) begin
        e_valid = 1'b1;
        e_en    = 4'b0001;
        e_num   = 3'd1;
        e_lanes = '0;
        e_base  = m_pc;
        e_exc   = 1'b1;
        e_code  = 5'h04;
        e_ref   = 1'b0;
        m_halt  = 1'b1;
      end else if (acc) begin
        m_out = 1'b1;
      end
    end

    if (bus.inst_data_ok) c_pend = 1'b0;
    if (bus.inst_req && bus.inst_addr_ok) begin
      c_pend = 1'b1;
      c_wait = int'($urandom_range(lat_lo, lat_hi));
    end

    @(posedge clk);
    #1;
    got_valid = bus.IF_valid_o;
    got_en    = bus.IF_instEnable_o;
    got_num   = bus.IF_instNum_o;
    got_lanes = bus.IF_inst_p_o;
    got_base  = bus.IF_instBasePC_o;
    got_exc   = bus.IF_hasException_o;
    got_code  = bus.IF_ExcCode_o;
    got_ref   = bus.IF_isRefill_o;
    chk("IF_valid", got_valid, e_valid);
    if (e_valid) begin
      chk("IF_instEnable", got_en, e_en);
      chk("IF_instNum", got_num, e_num);
      chk("IF_inst_p", got_lanes, e_lanes);
      chk("IF_instBasePC", got_base, e_base);
      chk("IF_hasException", got_exc, e_exc);
      chk("IF_ExcCode", got_code, e_code);
      chk("IF_isRefill", got_ref, e_ref);
    end
    if (got_valid) n_valid_seen++;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      cycle(1'b0, 32'h0);
      if (got_valid) break;
    end
    chk("valid_within_bound", got_valid, 1'b1);
  endtask

  initial begin
    logic [31:0] first_addr;
    bit          first_seen;
    logic [31:0] tgt;

    rst = 1'b1;
    bus.redirect_i = 1'b0; bus.redirectPC_i = '0; bus.ID_stopFetch_i = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    bus.inst_excOccur = 1'b0; bus.inst_excCode = '0; bus.inst_isRefill = 1'b0;
    ok_pct = 100; lat_lo = 1; lat_hi = 1; exc_pct = 0;
    fixed_data = 1'b1; force_exc = 1'b0; stop = 1'b0;
    fixed_rdata = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    c_pend = 1'b0; c_wait = 0;
    m_pc = 32'hBFC0_0000; m_out = 1'b0; m_disc = 1'b0; m_halt = 1'b0;
    n_req_seen = 0; n_valid_seen = 0;
    #1 rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_inst_req", bus.inst_req, 1'b0);
    chk("rst_inst_addr", bus.inst_addr, 32'h0);
    chk("rst_IF_valid", bus.IF_valid_o, 1'b0);
    chk("rst_IF_instNum", bus.IF_instNum_o, 3'd0);
    rst = 1'b1;

    // First fetch from the reset vector, full block
    cycle(1'b0, 32'h0);
    chk("first_req", got_req, 1'b1);
    chk("first_addr", got_addr, 32'hBFC0_0000);
    wait_valid(8);
    chk("blk0_lanes", got_lanes, {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000});
    chk("blk0_en", got_en, 4'b1111);
    chk("blk0_num", got_num, 3'd4);
    chk("blk0_base", got_base, 32'hBFC0_0000);
    cycle(1'b0, 32'h0);
    chk("blk1_addr", got_addr, 32'hBFC0_0010);

    // Redirect mid-word-block: partial packet
    fixed_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    cycle(1'b1, 32'h8000_0008);
    wait_valid(10);
    chk("partial_en", got_en, 4'b0011);
    chk("partial_num", got_num, 3'd2);
    chk("partial_lanes", got_lanes, {64'h0, 32'h3333_0003, 32'h2222_0002});
    chk("partial_base", got_base, 32'h8000_0008);
    cycle(1'b0, 32'h0);
    chk("partial_next_addr", got_addr, 32'h8000_0010);

    // Redirect while waiting: stale response must not produce a packet
    cycle(1'b1, 32'h9000_0040);
    n_valid_seen = 0; first_seen = 1'b0; first_addr = '0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0);
      if (got_req && !first_seen) begin first_seen = 1'b1; first_addr = got_addr; end
    end
    chk("stale_no_valid", 32'(n_valid_seen), 32'd0);
    chk("redirect_target_addr", first_addr, 32'h9000_0040);
    wait_valid(10);

    // Misaligned redirect: address-error packet, then silence
    cycle(1'b1, 32'h8000_0002);
    wait_valid(12);
    chk("adel_exc", got_exc, 1'b1);
    chk("adel_code", got_code, 5'h04);
    chk("adel_num", got_num, 3'd1);
    chk("adel_en", got_en, 4'b0001);
    chk("adel_base", got_base, 32'h8000_0002);
    n_req_seen = 0; n_valid_seen = 0;
    repeat (8) cycle(1'b0, 32'h0);
    chk("adel_halt_req", 32'(n_req_seen), 32'd0);
    chk("adel_halt_valid", 32'(n_valid_seen), 32'd0);

    // Back-pressure during an in-flight fetch
    lat_lo = 2; lat_hi = 2;
    cycle(1'b1, 32'h8000_1000);
    cycle(1'b0, 32'h0);
    stop = 1'b1; n_req_seen = 0;
    wait_valid(10);
    repeat (3) cycle(1'b0, 32'h0);
    chk("stop_no_req", 32'(n_req_seen), 32'd0);
    stop = 1'b0;
    lat_lo = 1; lat_hi = 1;
    cycle(1'b0, 32'h0);
    chk("stop_release_req", got_req, 1'b1);
    chk("stop_release_addr", got_addr, 32'h8000_1010);

    // Translation exception on the response, then halt
    force_exc = 1'b1;
    wait_valid(10);
    chk("tlb_exc", got_exc, 1'b1);
    chk("tlb_code", got_code, 5'h03);
    chk("tlb_refill", got_ref, 1'b1);
    force_exc = 1'b0;
    n_req_seen = 0;
    repeat (8) cycle(1'b0, 32'h0);
    chk("tlb_halt_req", 32'(n_req_seen), 32'd0);

    // PC wrap at the top of the address space
    cycle(1'b1, 32'hFFFF_FFF4);
    wait_valid(10);
    chk("wrap_num", got_num, 3'd3);
    cycle(1'b0, 32'h0);
    chk("wrap_req", got_req, 1'b1);
    chk("wrap_addr", got_addr, 32'h0000_0000);

    // Randomized run
    fixed_data = 1'b0; ok_pct = 60; lat_lo = 0; lat_hi = 3; exc_pct = 5;
    for (int n = 0; n < 3000; n++) begin
      stop = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 7))
          0:       tgt = $urandom() | 32'h1;
          1:       tgt = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
          default: tgt = $urandom() & ~32'h3;
        endcase
        cycle(1'b1, tgt);
      end else begin
        cycle(1'b0, 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_packet_gen.md
FETCH_PACKET_GEN -- requirements
Module: fetch_packet_gen

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC0_0000, fetch PC after reset.
REQ-002 Parameter: ADEL_CODE, 5'h04, ExcCode for a misaligned fetch PC.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 redirect_i  in  1  flush/redirect pulse from branch resolution or CP0.
REQ-006 redirectPC_i  in  32  redirect target, valid while redirect_i=1.
REQ-007 ID_stopFetch_i  in  1  instruction-queue almost-full back-pressure.
REQ-008 inst_req  out  1  I-cache request valid.
REQ-009 inst_addr  out  32  request address, {PC[31:4],4'b0}.
REQ-010 inst_addr_ok  in  1  cache accepted request.
REQ-011 inst_data_ok  in  1  response valid, one cycle.
REQ-012 inst_rdata  in  128  16-byte block, word k at bits [32k+31:32k].
REQ-013 inst_excOccur / inst_excCode / inst_isRefill  in  1/5/1  translation exception returned with response.
REQ-014 IF_valid_o  out  1  packet valid, one cycle per packet.
REQ-015 IF_instEnable_o  out  4  thermometer lane enables.
REQ-016 IF_inst_p_o  out  128  lane i at bits [32i+31:32i].
REQ-017 IF_instNum_o  out  3  enabled-lane count, 1..4.
REQ-018 IF_instBasePC_o  out  32  PC of lane 0.
REQ-019 IF_hasException_o / IF_ExcCode_o / IF_isRefill_o  out  1/5/1  exception info for the whole packet.

Function
REQ-020 States: REQ, WAIT, CANCEL, HALT.
REQ-021 Transitions from REQ:
- Issue request, inst_req=1, when PC[1:0]==0 and ID_stopFetch_i=0.
- Move to WAIT on inst_req&&inst_addr_ok.
REQ-022 Misaligned PC in REQ (PC[1:0]!=0): no cache request. Emit one packet next cycle with hasException=1, ExcCode=ADEL_CODE, isRefill=0, instEnable=4'b0001, instNum=1, basePC=PC. Then go to HALT.
REQ-023 Only one request is outstanding at a time; inst_req is held with constant inst_addr until inst_addr_ok.
REQ-024 WAIT, on inst_data_ok:
- Registered output next cycle with IF_valid_o=1.
- count=4-PC[3:2]; instEnable=(1<<count)-1; instNum=count.
- Lane i=word (PC[3:2]+i) for i<count; disabled lanes are 0.
- basePC=PC.
- Exception fields copied from the response.
REQ-025 After data_ok without exception: PC<= {PC[31:4]+1,4'b0}, go to REQ.
REQ-026 After data_ok with exception: go to HALT, PC unchanged.
REQ-027 In HALT, no requests are issued until redirect_i.
REQ-028 ID_stopFetch_i blocks only new requests. An in-flight response is still delivered.
REQ-029 redirect_i (highest priority), any state:
- PC<=redirectPC_i.
- Any pending or next-cycle IF_valid_o is suppressed.
- In REQ with no accept, or in HALT: go to REQ.
- In WAIT, or in REQ with a same-cycle accept: go to CANCEL.
REQ-030 CANCEL: discard the next inst_data_ok with no packet out, then go to REQ. redirect_i during CANCEL updates PC only.
REQ-031 redirect_i coincident with inst_data_ok in WAIT: data is discarded, go to REQ, no packet.
REQ-032 PC increment wraps modulo 2^32; 32'hFFFF_FFF0 is followed by 32'h0000_0000.

Reset
REQ-033 rst low: state=REQ, PC=RESET_PC, all outputs 0. Any in-flight response is forgotten.
REQ-034 First request is issued in the first cycle after rst deasserts, inst_addr=32'hBFC0_0000.

Verification
REQ-035 Reset, addr_ok immediate, data_ok 2 cycles later with rdata words A,B,C,D -> packet enable=1111, num=4, basePC=BFC00000, lanes A,B,C,D; next inst_addr=BFC00010.
REQ-036 Redirect to 0x8000_0008, response words W0..W3 -> enable=0011, num=2, lanes W2,W3, basePC=80000008; next addr=80000010.
REQ-037 Redirect while in WAIT, then stale data_ok -> no IF_valid_o. Next inst_addr equals the target block.
REQ-038 Redirect to 0x8000_0002 -> no inst_req; packet hasException=1, ExcCode=04, num=1; then silence until the next redirect.
REQ-039 ID_stopFetch_i high during WAIT -> packet still delivered; inst_req stays 0 until stop drops.
REQ-040 Response with inst_excOccur=1, excCode=03, isRefill=1 -> packet carries 1/03/1, then HALT with no further requests.
